bit_serial_conv_engine: RTL and testbench
=========================================

// Module: bit_serial_conv_engine
// PURPOSE
// - Parametrised bit-serial CIM convolution engine; successor of the fixed 32-channel serial Convolution block.
// - Each accepted beat carries one activation bit-plane (one bit per channel, LSB plane first).
// - Per beat: weighted sum of the plane's bits times per-channel signed weights, shift-accumulated over ACT_BITS beats.
// - Adds a runtime weight RAM, in/out valid-ready handshakes and signed-activation support.
// PARAMETERS
// - N_CH        32  channels (serial input lanes), >=2
// - ACT_BITS    8   activation bits per frame = beats per frame, >=2
// - WGT_BITS    4   signed two's-complement weight width
// - SIGNED_ACT  0   1: activations are two's complement (MSB plane weighted -2^(ACT_BITS-1))
// - localparam OUT_W = ACT_BITS + WGT_BITS + $clog2(N_CH)  (default 17)
// PORTS
// - clk        in   1                clock, rising edge
// - rst        in   1                asynchronous, active-high reset
// - wt_we      in   1                weight write strobe
// - wt_addr    in   $clog2(N_CH)     weight channel index
// - wt_data    in   WGT_BITS         signed weight
// - wt_err     out  1                1-cycle pulse: write dropped (engine busy)
// - in_valid   in   1                bit-plane beat valid
// - in_ready   out  1                engine can accept a beat
// - in_ifm     in   N_CH             bit-plane, bit k = channel k
// - out_valid  out  1                Out_OFM holds a result
// - out_ready  in   1                consumer accepts result
// - Out_OFM    out  OUT_W            signed convolution result
// BEHAVIOUR
// - Reset: out_valid=0, Out_OFM=0, wt_err=0, accumulator=0, bit counter=0, all weights=0, FSM=IDLE.
// - Reset mid-frame discards the partial frame; no result is produced for it.
// - Beat accepted when in_valid & in_ready. in_valid low mid-frame = stall: counter and accumulator hold.
// - FSM: IDLE -(first beat)-> ACC; ACC -(beat ACT_BITS-1 accepted)-> IDLE, result loaded.
// - If ACT_BITS-1 == 0 is impossible; ACT_BITS>=2 so ACC always has >=1 cycle.
// - Partial p = sum over k of in_ifm[k] ? w[k] : 0, signed, width WGT_BITS+$clog2(N_CH).
// - acc += sext(p) << b for plane b; if SIGNED_ACT=1 and b==ACT_BITS-1, acc -= sext(p) << b instead.
// - All arithmetic is signed at OUT_W bits; no overflow is possible at declared widths.
// - Last beat: final acc (including that beat) registered into Out_OFM; out_valid=1 next cycle (latency 1 after last beat).
// - Accumulator clears on the last beat; back-to-back frames need no idle cycle.
// - in_ready = ~(out_valid & ~out_ready). Held result is never overwritten.
// - Last beat while out_valid & out_ready: old result retires, new loads, out_valid stays 1.
// - out_valid & out_ready without a new last beat: out_valid->0 next cycle, Out_OFM holds value.
// - wt_we in IDLE with counter==0: w[wt_addr] <= wt_data next edge; new weight used from the next beat.
// - wt_we while in ACC, or in the same cycle as an accepted beat: write dropped, wt_err=1 for one cycle.
// - Out_OFM is stable while out_valid=1 and out_ready=0.
// CONFIGURATION
// - Macro CONV_RELU_EN defined: a negative final result is clamped to 0 before loading Out_OFM.
// - Clamped result is loaded with out_valid=1 as usual.
// - Macro CONV_RELU_EN undefined: signed result passes unchanged; all other behaviour is identical.
// TESTING
// - Setup: all 32 weights=+1, 8 beats of in_ifm=all-ones, out_ready=1 -> Out_OFM=8160 one cycle after beat 8.
// - Setup: w[0]=-8, others 0; ch0 activation 3 (beats 1,1,0..0) -> Out_OFM=-24 (17'h1FFE8).
// - Same with CONV_RELU_EN defined -> Out_OFM=0.
// - SIGNED_ACT=1, all weights +1, activation 8'h80 on all channels -> Out_OFM=-4096.
// - out_ready=0, two frames streamed -> in_ready drops after frame 2 last beat pending.
// - Release out_ready -> results 8160 then 8160 in order, none lost.
// - rst pulse after beat 4 of a frame -> out_valid=0 and weights=0.
// - After reload, a fresh full frame gives the correct result.
// - wt_we during beat 3 -> wt_err pulses 1 cycle and the weight is unchanged.

Source files
------------

// File: rtl/bit_serial_conv_engine.sv
// ============================================================================
// Module     : bit_serial_conv_engine
// Description: Bit-serial CIM convolution engine. Weighted bit-plane sums are
//              shift-accumulated over ACT_BITS beats. CONV_RELU_EN clamps
//              negative results to zero.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_conv_engine #(
  parameter int N_CH       = 32,
  parameter int ACT_BITS   = 8,
  parameter int WGT_BITS   = 4,
  parameter int SIGNED_ACT = 0,
  localparam int OUT_W     = ACT_BITS + WGT_BITS + $clog2(N_CH),
  localparam int AW        = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wt_we,
  input  logic [AW-1:0]       wt_addr,
  input  logic [WGT_BITS-1:0] wt_data,
  output logic                wt_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_CH-1:0]     in_ifm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    Out_OFM
);

  localparam int PW    = WGT_BITS + AW;
  localparam int CNT_W = $clog2(ACT_BITS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACT_BITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_bitcnt;
  logic signed [OUT_W-1:0]     r_acc;
  logic signed [OUT_W-1:0]     r_ofm;
  logic                        r_out_valid;
  logic                        r_wt_err;
  logic signed [WGT_BITS-1:0]  r_wgt [N_CH];

  logic                        w_beat;
  logic                        w_last;
  logic                        w_wt_idle;
  logic                        w_wt_write;
  logic signed [PW-1:0]        w_psum;
  logic signed [OUT_W-1:0]     w_ext;
  logic signed [OUT_W-1:0]     w_term;
  logic                        w_neg;
  logic signed [OUT_W-1:0]     w_acc_next;
  logic signed [OUT_W-1:0]     w_result;

  assign in_ready  = ~(r_out_valid & ~out_ready);
  assign w_beat    = in_valid & in_ready;
  assign w_last    = w_beat & (r_bitcnt == LAST_BEAT);

  // Weights may only change between frames so a frame never mixes weight sets.
  assign w_wt_idle  = (r_state == S_IDLE) & (r_bitcnt == '0) & ~w_beat;
  assign w_wt_write = wt_we & w_wt_idle & (32'(wt_addr) < N_CH);

  always_comb begin
    w_psum = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (in_ifm[k]) begin
        w_psum = w_psum + {{(PW - WGT_BITS){r_wgt[k][WGT_BITS-1]}}, r_wgt[k]};
      end
    end
  end

  assign w_ext      = {{(OUT_W - PW){w_psum[PW-1]}}, w_psum};
  assign w_term     = w_ext << r_bitcnt;
  assign w_neg      = (SIGNED_ACT != 0) && (r_bitcnt == LAST_BEAT);
  assign w_acc_next = w_neg ? (r_acc - w_term) : (r_acc + w_term);

`ifdef CONV_RELU_EN
  assign w_result = w_acc_next[OUT_W-1] ? '0 : w_acc_next;
`else
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_acc       <= '0;
      r_ofm       <= '0;
      r_out_valid <= 1'b0;
      r_wt_err    <= 1'b0;
    end else begin
      r_wt_err <= wt_we & ~w_wt_idle;
      if (w_beat) begin
        if (w_last) begin
          r_state     <= S_IDLE;
          r_bitcnt    <= '0;
          r_acc       <= '0;
          r_ofm       <= w_result;
          r_out_valid <= 1'b1;
        end else begin
          r_state  <= S_ACC;
          r_bitcnt <= r_bitcnt + 1'b1;
          r_acc    <= w_acc_next;
        end
      end
      // Retire a consumed result unless a new one is loading in the same cycle.
      if (r_out_valid && out_ready && !w_last) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_wgt[k] <= '0;
      end
    end else if (w_wt_write) begin
      r_wgt[wt_addr] <= wt_data;
    end
  end

  assign Out_OFM   = r_ofm;
  assign out_valid = r_out_valid;
  assign wt_err    = r_wt_err;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_conv_engine.sv
// ============================================================================
// Module     : tb_bit_serial_conv_engine
// Description: Scoreboard bench; unsigned and signed-activation engines share stimulus.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_conv_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wt_we = 1'b0;
  logic [4:0]  wt_addr = '0;
  logic [3:0]  wt_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ifm = '0;
  logic        out_ready = 1'b1;

  logic        wt_err_u, in_ready_u, out_valid_u;
  logic [16:0] ofm_u;
  logic        wt_err_s, in_ready_s, out_valid_s;
  logic [16:0] ofm_s;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] q_u[$];
  logic [16:0] q_s[$];

  bit_serial_conv_engine #(.N_CH(32), .ACT_BITS(8), .WGT_BITS(4), .SIGNED_ACT(0)) u_dut (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .wt_err(wt_err_u), .in_valid(in_valid), .in_ready(in_ready_u), .in_ifm(in_ifm),
    .out_valid(out_valid_u), .out_ready(out_ready), .Out_OFM(ofm_u)
  );

  bit_serial_conv_engine #(.N_CH(32), .ACT_BITS(8), .WGT_BITS(4), .SIGNED_ACT(1)) u_dut_s (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .wt_err(wt_err_s), .in_valid(in_valid), .in_ready(in_ready_s), .in_ifm(in_ifm),
    .out_valid(out_valid_s), .out_ready(out_ready), .Out_OFM(ofm_s)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] rl(input int x);
`ifdef CONV_RELU_EN
    return (x < 0) ? 17'd0 : 17'(x);
`else
    return 17'(x);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_u && out_ready) begin
        n_vec++;
        if (q_u.size() == 0) begin
          n_err++;
          $display("FAIL unexp_u: got %0h expected no result", ofm_u);
        end else begin
          logic [16:0] e;
          e = q_u.pop_front();
          if (ofm_u !== e) begin
            n_err++;
            $display("FAIL result_u: got %0h expected %0h", ofm_u, e);
          end
        end
      end
      if (out_valid_s && out_ready) begin
        n_vec++;
        if (q_s.size() == 0) begin
          n_err++;
          $display("FAIL unexp_s: got %0h expected no result", ofm_s);
        end else begin
          logic [16:0] e;
          e = q_s.pop_front();
          if (ofm_s !== e) begin
            n_err++;
            $display("FAIL result_s: got %0h expected %0h", ofm_s, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_wt(input int addr, input logic [3:0] data);
    wt_we   = 1'b1;
    wt_addr = 5'(addr);
    wt_data = data;
    tick();
    wt_we   = 1'b0;
  endtask

  task automatic load_all(input logic [3:0] data);
    for (int k = 0; k < 32; k++) write_wt(k, data);
  endtask

  // Holds the beat until a clock edge where in_ready is high.
  task automatic send_beat(input logic [31:0] v);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_ifm = v;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready_u;
      tick();
      t++;
    end
    in_valid = 1'b0;
    wt_we = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send_frame(input logic [7:0] a_all, input logic [7:0] a0,
                            input bit stall, input int err_beat);
    for (int b = 0; b < 8; b++) begin
      if (stall) tick();
      if (b == err_beat) begin
        wt_we   = 1'b1;
        wt_addr = 5'd0;
        wt_data = 4'h8;
      end
      send_beat({{31{a_all[b]}}, a0[b]});
      if (b == err_beat) begin
        chk("wt_err_pulse", {31'd0, wt_err_u}, 32'd1);
        tick();
        chk("wt_err_clear", {31'd0, wt_err_u}, 32'd0);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
    chk("rst_ofm", {15'd0, ofm_u}, 32'd0);
    chk("rst_wt_err", {31'd0, wt_err_u}, 32'd0);
    chk("rst_ofm_s", {15'd0, ofm_s}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready_u}, 32'd1);

    // All weights +1, all-ones activation.
    load_all(4'h1);
    q_u.push_back(rl(8160));
    q_s.push_back(rl(-32));
    send_frame(8'hFF, 8'hFF, 1'b0, -1);
    chk("latency_valid", {31'd0, out_valid_u}, 32'd1);

    // Back-to-back frame: only the MSB plane set, with stalls between beats.
    q_u.push_back(rl(4096));
    q_s.push_back(rl(-4096));
    send_frame(8'h80, 8'h80, 1'b1, -1);

    // w[0]=-8, ch0 activation 3.
    tick();
    write_wt(0, 4'h8);
    for (int k = 1; k < 32; k++) write_wt(k, 4'h0);
    q_u.push_back(rl(-24));
    q_s.push_back(rl(-24));
    send_frame(8'h00, 8'h03, 1'b0, -1);

    // Backpressure: frame 2 must wait until result 1 is consumed.
    tick();
    load_all(4'h1);
    out_ready = 1'b0;
    q_u.push_back(rl(8160));
    q_s.push_back(rl(-32));
    q_u.push_back(rl(8160));
    q_s.push_back(rl(-32));
    send_frame(8'hFF, 8'hFF, 1'b0, -1);
    repeat (3) tick();
    chk("bp_in_ready", {31'd0, in_ready_u}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid_u}, 32'd1);
    chk("bp_hold_ofm", {15'd0, ofm_u}, 32'(rl(8160)));
    fork
      begin
        repeat (4) tick();
        out_ready = 1'b1;
      end
      send_frame(8'hFF, 8'hFF, 1'b0, -1);
    join
    repeat (3) tick();

    // Reset after beat 4 discards the partial frame and clears weights.
    for (int b = 0; b < 4; b++) send_beat(32'hFFFF_FFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, out_valid_u}, 32'd0);
    q_u.push_back(17'd0);
    q_s.push_back(17'd0);
    send_frame(8'hFF, 8'hFF, 1'b0, -1);
    tick();
    load_all(4'h1);
    q_u.push_back(rl(8160));
    q_s.push_back(rl(-32));
    send_frame(8'hFF, 8'hFF, 1'b0, -1);

    // Weight write during beat 3 is dropped.
    tick();
    q_u.push_back(rl(8160));
    q_s.push_back(rl(-32));
    send_frame(8'hFF, 8'hFF, 1'b0, 2);

    for (int t = 0; t < 100 && (q_u.size() != 0 || q_s.size() != 0); t++) tick();
    chk("drain_u", q_u.size(), 32'd0);
    chk("drain_s", q_s.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
